tt_mask_idx_rx: RTL and testbench



---
 rtl/tt_mask_idx_pkg.sv | 23 ++
 rtl/tt_mask_idx_rx_if.sv | 32 +++
 rtl/tt_mask_idx_rx_fifo.sv | 53 +++++
 rtl/tt_mask_idx_rx.sv | 179 +++++++++++++++++
 tb/tb_tt_mask_idx_rx.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_mask_idx_pkg.sv
// Shared types for the LSU-side mask/index receiver: item layout, FSM states,
// and the item count an op expects.
package tt_mask_idx_pkg;

  localparam int MASK_CHUNK_BITS = 64;

  typedef struct packed {
    logic                       mask;
    logic [MASK_CHUNK_BITS-1:0] payload;
  } mask_idx_item_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT
  } rx_state_e;

  // Indexed ops send one item per element, masked ops one item per 64 elements.
  function automatic int items_for_vl(input int vl, input logic is_indexed);
    return is_indexed ? vl : (vl + MASK_CHUNK_BITS - 1) / MASK_CHUNK_BITS;
  endfunction

endpackage

// File: rtl/tt_mask_idx_rx_if.sv
// Mask/index credit channel plus the serialised element channel toward the
// LSU address generator. master = transmitter/consumer side, slave = receiver.
interface tt_mask_idx_rx_if #(
  parameter int VLEN = 256
);
  import tt_mask_idx_pkg::*;

  localparam int NUM_W = $clog2(VLEN);

  logic           mask_idx_valid;
  mask_idx_item_t mask_idx_item;
  logic           mask_idx_last_idx;
  logic           mask_idx_credit;

  logic             elem_valid;
  logic             elem_ready;
  logic             elem_active;
  logic [63:0]      elem_index;
  logic [NUM_W-1:0] elem_num;
  logic             elem_last;

  modport master (
    output mask_idx_valid, mask_idx_item, mask_idx_last_idx, elem_ready,
    input  mask_idx_credit, elem_valid, elem_active, elem_index, elem_num, elem_last
  );

  modport slave (
    input  mask_idx_valid, mask_idx_item, mask_idx_last_idx, elem_ready,
    output mask_idx_credit, elem_valid, elem_active, elem_index, elem_num, elem_last
  );

endinterface

// File: rtl/tt_mask_idx_rx_fifo.sv
// Small synchronous FIFO; a push while full is taken only if a pop happens in
// the same cycle, otherwise the data is dropped.
module tt_mask_idx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = mem[rd_ptr_q];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/tt_mask_idx_rx.sv
// LSU-side mask/index receiver: buffers credited items and serialises them into
// one element per handshake. Optional TT_MASK_IDX_RX_ERR_EN adds sticky o_proto_err.
module tt_mask_idx_rx
  import tt_mask_idx_pkg::*;
#(
  parameter int VLEN         = 256,
  parameter int MASK_CREDITS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_memop_start,
  input  logic [$clog2(VLEN+1)-1:0] i_vl,
  input  logic                      i_is_indexed,
  input  logic                      i_is_masked,
  tt_mask_idx_rx_if.slave           bus,
  output logic                      o_done
`ifdef TT_MASK_IDX_RX_ERR_EN
  ,
  output logic                      o_proto_err
`endif
);

  localparam int VL_W    = $clog2(VLEN + 1);
  localparam int NUM_W   = $clog2(VLEN);
  localparam int CHUNK_W = $clog2(MASK_CHUNK_BITS);

  rx_state_e            state_q, state_d;
  logic [VL_W-1:0]      vl_q;
  logic                 indexed_q, masked_q;
  logic [NUM_W-1:0]     elem_cnt_q;
  logic [CHUNK_W-1:0]   chunk_cnt_q;
  logic [63:0]          shift_q;
  logic                 credit_q, done_q, done_d;
  logic                 pop, accept, is_last, load_chunk;
  logic                 elem_valid, elem_active;
  logic [63:0]          elem_index;
  logic                 fifo_empty, fifo_full;
  logic [$bits(mask_idx_item_t)-1:0] head_raw;
  mask_idx_item_t       head;

  tt_mask_idx_fifo #(
    .DEPTH (MASK_CREDITS),
    .WIDTH ($bits(mask_idx_item_t))
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (bus.mask_idx_valid),
    .i_push_data (bus.mask_idx_item),
    .i_pop       (pop),
    .o_head      (head_raw),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  assign head       = mask_idx_item_t'(head_raw);
  assign accept     = elem_valid && bus.elem_ready;
  assign is_last    = (VL_W'(elem_cnt_q) == vl_q - VL_W'(1));
  assign load_chunk = (state_q == ST_LOAD) && !indexed_q && !fifo_empty;

  // Indexed ops present the FIFO head directly in LOAD and EMIT; LOAD only
  // means "no element seen yet". Masked ops go through the shift register.
  always_comb begin
    state_d     = state_q;
    elem_valid  = 1'b0;
    elem_active = 1'b0;
    elem_index  = '0;
    pop         = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_memop_start) begin
          if (i_vl == '0)                     done_d  = 1'b1;
          else if (i_is_indexed || i_is_masked) state_d = ST_LOAD;
          else                                state_d = ST_EMIT;
        end
      end
      ST_LOAD, ST_EMIT: begin
        if (indexed_q) begin
          elem_valid  = !fifo_empty;
          elem_active = head.mask;
          elem_index  = head.payload;
          pop         = accept;
          if (accept && is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (!fifo_empty) begin
            state_d = ST_EMIT;
          end
        end else if (state_q == ST_LOAD) begin
          pop = load_chunk;
          if (load_chunk) state_d = ST_EMIT;
        end else begin
          elem_valid  = 1'b1;
          elem_active = masked_q ? shift_q[0] : 1'b1;
          if (accept) begin
            if (is_last) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (masked_q && chunk_cnt_q == CHUNK_W'(MASK_CHUNK_BITS - 1)) begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      vl_q        <= '0;
      indexed_q   <= 1'b0;
      masked_q    <= 1'b0;
      elem_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      shift_q     <= '0;
      credit_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= pop;
      done_q   <= done_d;
      if (state_q == ST_IDLE && i_memop_start) begin
        vl_q        <= i_vl;
        indexed_q   <= i_is_indexed;
        masked_q    <= i_is_masked;
        elem_cnt_q  <= '0;
        chunk_cnt_q <= '0;
      end
      if (accept) begin
        elem_cnt_q  <= elem_cnt_q + NUM_W'(1);
        chunk_cnt_q <= chunk_cnt_q + CHUNK_W'(1);
        shift_q     <= shift_q >> 1;
      end
      if (load_chunk) begin
        shift_q     <= head.payload;
        chunk_cnt_q <= '0;
      end
    end
  end

  assign bus.mask_idx_credit = credit_q;
  assign bus.elem_valid      = elem_valid;
  assign bus.elem_active     = elem_valid && elem_active;
  assign bus.elem_index      = elem_valid ? elem_index : '0;
  assign bus.elem_num        = elem_valid ? elem_cnt_q : '0;
  assign bus.elem_last       = elem_valid && is_last;
  assign o_done              = done_q;

`ifdef TT_MASK_IDX_RX_ERR_EN
  logic [VL_W-1:0] push_cnt_q;
  logic            err_q, err_set, last_exp;

  assign last_exp = (int'(push_cnt_q) == items_for_vl(int'(vl_q), indexed_q) - 1);
  assign err_set  = (bus.mask_idx_valid && fifo_full && !pop)
                 || (bus.mask_idx_valid && state_q == ST_IDLE)
                 || (i_memop_start && state_q != ST_IDLE)
                 || (bus.mask_idx_valid && state_q != ST_IDLE
                     && (bus.mask_idx_last_idx != last_exp));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      push_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && i_memop_start) push_cnt_q <= '0;
      else if (bus.mask_idx_valid)             push_cnt_q <= push_cnt_q + VL_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign o_proto_err = err_q;
`else
  logic unused_sigs;
  assign unused_sigs = fifo_full ^ bus.mask_idx_last_idx;
`endif

endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Directed bench for tt_mask_idx_rx; covers the optional error output when
// TT_MASK_IDX_RX_ERR_EN is defined.
module tb_tt_mask_idx_rx;
  import tt_mask_idx_pkg::*;

  localparam int VLEN = 256;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_memop_start = 1'b0;
  logic [8:0] i_vl = '0;
  logic       i_is_indexed = 1'b0;
  logic       i_is_masked = 1'b0;
  logic       o_done;
`ifdef TT_MASK_IDX_RX_ERR_EN
  logic       o_proto_err;
`endif

  int checks = 0;
  int failures = 0;

  tt_mask_idx_rx_if #(.VLEN(VLEN)) bus ();

  tt_mask_idx_rx #(.VLEN(VLEN), .MASK_CREDITS(2)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_memop_start (i_memop_start),
    .i_vl          (i_vl),
    .i_is_indexed  (i_is_indexed),
    .i_is_masked   (i_is_masked),
    .bus           (bus),
    .o_done        (o_done)
`ifdef TT_MASK_IDX_RX_ERR_EN
    ,
    .o_proto_err   (o_proto_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Observation at the falling edge: counts pulses and records accepted elements.
  int          credit_cnt, done_cnt, stall_viol;
  logic        rec_active[$];
  logic [63:0] rec_index[$];
  logic [7:0]  rec_num[$];
  logic        rec_last[$];
  logic        stall_prev = 1'b0;
  logic [73:0] stall_vec;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.mask_idx_credit) credit_cnt++;
      if (o_done) done_cnt++;
      if (stall_prev && !(bus.elem_valid &&
          {bus.elem_active, bus.elem_index, bus.elem_num, bus.elem_last} == stall_vec))
        stall_viol++;
      if (bus.elem_valid && bus.elem_ready) begin
        rec_active.push_back(bus.elem_active);
        rec_index.push_back(bus.elem_index);
        rec_num.push_back(bus.elem_num);
        rec_last.push_back(bus.elem_last);
      end
      stall_prev = bus.elem_valid && !bus.elem_ready;
      stall_vec  = {bus.elem_active, bus.elem_index, bus.elem_num, bus.elem_last};
    end
  end

  task automatic clear_mon();
    credit_cnt = 0; done_cnt = 0; stall_viol = 0;
    rec_active.delete(); rec_index.delete(); rec_num.delete(); rec_last.delete();
  endtask

  task automatic do_start(input logic [8:0] vl, input logic idx, input logic msk);
    i_vl = vl; i_is_indexed = idx; i_is_masked = msk; i_memop_start = 1'b1;
    @(posedge i_clk); #1;
    i_memop_start = 1'b0;
  endtask

  task automatic push_item(input logic m, input logic [63:0] p, input logic last);
    bus.mask_idx_valid = 1'b1; bus.mask_idx_item = {m, p}; bus.mask_idx_last_idx = last;
    @(posedge i_clk); #1;
    bus.mask_idx_valid = 1'b0; bus.mask_idx_last_idx = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge i_clk); #1; n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++; $display("FAIL wait_done: no o_done within %0d cycles", budget);
    end
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mask_idx_valid = 1'b0; bus.mask_idx_item = '0; bus.mask_idx_last_idx = 1'b0;
    bus.elem_ready = 1'b0;
    clear_mon();
    #12;
    checks++;
    if ({bus.elem_valid, bus.mask_idx_credit, o_done} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000", {bus.elem_valid, bus.mask_idx_credit, o_done});
    end
    checks++;
    if ({bus.elem_active, bus.elem_index, bus.elem_num, bus.elem_last} !== 74'd0) begin
      failures++; $display("FAIL reset_elem: got %h want 0", {bus.elem_active, bus.elem_index, bus.elem_num, bus.elem_last});
    end
`ifdef TT_MASK_IDX_RX_ERR_EN
    checks++;
    if (o_proto_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", o_proto_err); end
`endif
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_indexed();
    logic        exp_act[3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] exp_idx[3] = '{64'h10, 64'h20, 64'h30};
    clear_mon();
    bus.elem_ready = 1'b1;
    do_start(9'd3, 1'b1, 1'b0);
    push_item(1'b1, 64'h10, 1'b0);
    checks++;
    if ({bus.elem_valid, bus.elem_index} !== {1'b1, 64'h10}) begin
      failures++; $display("FAIL idx_latency: valid/index %b/%h want 1/10", bus.elem_valid, bus.elem_index);
    end
    push_item(1'b0, 64'h20, 1'b0);
    push_item(1'b1, 64'h30, 1'b1);
    wait_done(20);
    checks++;
    if (rec_active.size() !== 3) begin
      failures++; $display("FAIL idx_count: got %0d want 3", rec_active.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({rec_active[i], rec_index[i], rec_num[i], rec_last[i]} !== {exp_act[i], exp_idx[i], 8'(i), (i == 2)}) begin
          failures++;
          $display("FAIL idx_elem%0d: act/idx/num/last %b/%h/%0d/%b want %b/%h/%0d/%b", i,
                   rec_active[i], rec_index[i], rec_num[i], rec_last[i], exp_act[i], exp_idx[i], i, (i == 2));
        end
      end
    end
    checks++;
    if (credit_cnt !== 3) begin failures++; $display("FAIL idx_credits: got %0d want 3", credit_cnt); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL idx_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_masked_strided();
    int bad = 0;
    clear_mon();
    bus.elem_ready = 1'b1;
    do_start(9'd70, 1'b0, 1'b1);
    bus.mask_idx_valid = 1'b1; bus.mask_idx_item = {1'b0, 64'h5}; bus.mask_idx_last_idx = 1'b0;
    @(posedge i_clk); #1;
    bus.mask_idx_item = {1'b0, 64'h3}; bus.mask_idx_last_idx = 1'b1;
    checks++;
    if (bus.elem_valid !== 1'b0) begin failures++; $display("FAIL msk_lat1: valid %b want 0", bus.elem_valid); end
    @(posedge i_clk); #1;
    bus.mask_idx_valid = 1'b0; bus.mask_idx_last_idx = 1'b0;
    checks++;
    if ({bus.elem_valid, bus.elem_active, bus.elem_num} !== {2'b11, 8'd0}) begin
      failures++; $display("FAIL msk_lat2: valid/active/num %b/%b/%0d want 1/1/0", bus.elem_valid, bus.elem_active, bus.elem_num);
    end
    wait_done(200);
    checks++;
    if (rec_active.size() !== 70) begin
      failures++; $display("FAIL msk_count: got %0d want 70", rec_active.size());
    end else begin
      for (int i = 0; i < 70; i++) begin
        logic ea;
        ea = (i == 0 || i == 2 || i == 64 || i == 65);
        checks++;
        if ({rec_active[i], rec_index[i], rec_num[i], rec_last[i]} !== {ea, 64'd0, 8'(i), (i == 69)}) begin
          failures++; bad++;
          if (bad < 5)
            $display("FAIL msk_elem%0d: act/idx/num/last %b/%h/%0d/%b want %b/0/%0d/%b", i,
                     rec_active[i], rec_index[i], rec_num[i], rec_last[i], ea, i, (i == 69));
        end
      end
    end
    checks++;
    if (credit_cnt !== 2) begin failures++; $display("FAIL msk_credits: got %0d want 2", credit_cnt); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL msk_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_unmasked_strided();
    clear_mon();
    bus.elem_ready = 1'b1;
    do_start(9'd5, 1'b0, 1'b0);
    wait_done(30);
    checks++;
    if (rec_active.size() !== 5) begin
      failures++; $display("FAIL unm_count: got %0d want 5", rec_active.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({rec_active[i], rec_index[i], rec_num[i], rec_last[i]} !== {1'b1, 64'd0, 8'(i), (i == 4)}) begin
          failures++;
          $display("FAIL unm_elem%0d: act/idx/num/last %b/%h/%0d/%b want 1/0/%0d/%b", i,
                   rec_active[i], rec_index[i], rec_num[i], rec_last[i], i, (i == 4));
        end
      end
    end
    checks++;
    if (credit_cnt !== 0) begin failures++; $display("FAIL unm_credits: got %0d want 0", credit_cnt); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL unm_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic        it_m[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] it_p[4] = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
    int pushed = 0;
    int cyc = 0;
    clear_mon();
    do_start(9'd4, 1'b1, 1'b0);
    while ((pushed < 4 || done_cnt == 0) && cyc < 80) begin
      bus.elem_ready = (cyc % 2 == 0);
      if (pushed < 4 && (2 - pushed + credit_cnt) > 0) begin
        bus.mask_idx_valid = 1'b1; bus.mask_idx_item = {it_m[pushed], it_p[pushed]};
        bus.mask_idx_last_idx = (pushed == 3);
        pushed++;
      end else begin
        bus.mask_idx_valid = 1'b0; bus.mask_idx_last_idx = 1'b0;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    bus.mask_idx_valid = 1'b0; bus.mask_idx_last_idx = 1'b0; bus.elem_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL b2b_done: got %0d want 1 after %0d cycles", done_cnt, cyc); end
    checks++;
    if (rec_active.size() !== 4) begin
      failures++; $display("FAIL b2b_count: got %0d want 4", rec_active.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({rec_active[i], rec_index[i], rec_num[i], rec_last[i]} !== {it_m[i], it_p[i], 8'(i), (i == 3)}) begin
          failures++;
          $display("FAIL b2b_elem%0d: act/idx/num/last %b/%h/%0d/%b want %b/%h/%0d/%b", i,
                   rec_active[i], rec_index[i], rec_num[i], rec_last[i], it_m[i], it_p[i], i, (i == 3));
        end
      end
    end
    checks++;
    if (stall_viol !== 0) begin failures++; $display("FAIL b2b_stall_stable: got %0d changes want 0", stall_viol); end
    checks++;
    if (credit_cnt !== 4) begin failures++; $display("FAIL b2b_credits: got %0d want 4", credit_cnt); end
  endtask

  task automatic test_vl_zero();
    clear_mon();
    bus.elem_ready = 1'b1;
    do_start(9'd0, 1'b1, 1'b0);
    checks++;
    if ({o_done, bus.elem_valid} !== 2'b10) begin
      failures++; $display("FAIL vl0_done: done/valid %b/%b want 1/0", o_done, bus.elem_valid);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_done !== 1'b0) begin failures++; $display("FAIL vl0_done_pulse: done %b want 0", o_done); end
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({rec_active.size(), credit_cnt, done_cnt} !== {32'd0, 32'd0, 32'd1}) begin
      failures++; $display("FAIL vl0_quiet: elems/credits/done %0d/%0d/%0d want 0/0/1", rec_active.size(), credit_cnt, done_cnt);
    end
  endtask

`ifdef TT_MASK_IDX_RX_ERR_EN
  task automatic test_proto_err();
    checks++;
    if (o_proto_err !== 1'b0) begin failures++; $display("FAIL err_clean: got %b want 0", o_proto_err); end
    clear_mon();
    bus.elem_ready = 1'b0;
    do_start(9'd4, 1'b1, 1'b0);
    push_item(1'b1, 64'h1, 1'b0);
    push_item(1'b1, 64'h2, 1'b0);
    checks++;
    if (o_proto_err !== 1'b0) begin failures++; $display("FAIL err_two_push: got %b want 0", o_proto_err); end
    push_item(1'b1, 64'h3, 1'b0);
    checks++;
    if (o_proto_err !== 1'b1) begin failures++; $display("FAIL err_overflow: got %b want 1", o_proto_err); end
    repeat (5) @(posedge i_clk);
    #1;
    checks++;
    if (o_proto_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", o_proto_err); end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_proto_err !== 1'b0) begin failures++; $display("FAIL err_reset: got %b want 0", o_proto_err); end
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask
`endif

  task automatic test_async_reset();
    clear_mon();
    bus.elem_ready = 1'b0;
    do_start(9'd4, 1'b1, 1'b0);
    push_item(1'b1, 64'hE1, 1'b0);
    push_item(1'b1, 64'hE2, 1'b0);
    checks++;
    if ({bus.elem_valid, bus.elem_index} !== {1'b1, 64'hE1}) begin
      failures++; $display("FAIL ares_pre: valid/index %b/%h want 1/e1", bus.elem_valid, bus.elem_index);
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.elem_valid, bus.mask_idx_credit, o_done, bus.elem_active, bus.elem_index, bus.elem_num, bus.elem_last} !== 77'd0) begin
      failures++; $display("FAIL ares_outputs: got %h want 0",
        {bus.elem_valid, bus.mask_idx_credit, o_done, bus.elem_active, bus.elem_index, bus.elem_num, bus.elem_last});
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    clear_mon();
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({done_cnt, credit_cnt} !== 64'd0) begin
      failures++; $display("FAIL ares_no_done: done/credits %0d/%0d want 0/0", done_cnt, credit_cnt);
    end
`ifdef TT_MASK_IDX_RX_ERR_EN
    checks++;
    if (o_proto_err !== 1'b0) begin failures++; $display("FAIL ares_err: got %b want 0", o_proto_err); end
`endif
    bus.elem_ready = 1'b1;
    do_start(9'd1, 1'b1, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (bus.elem_valid !== 1'b0) begin failures++; $display("FAIL ares_fifo_empty: valid %b want 0", bus.elem_valid); end
    push_item(1'b1, 64'h77, 1'b1);
    wait_done(20);
    checks++;
    if (rec_index.size() !== 1 || rec_index[0] !== 64'h77 || rec_last[0] !== 1'b1) begin
      failures++; $display("FAIL ares_after: %0d elems, first index %h want 1 elem index 77 last",
                           rec_index.size(), (rec_index.size() > 0) ? rec_index[0] : 64'd0);
    end
    checks++;
    if (credit_cnt !== 1) begin failures++; $display("FAIL ares_credits: got %0d want 1", credit_cnt); end
  endtask

  initial begin
    test_reset();
    test_indexed();
    test_masked_strided();
    test_unmasked_strided();
    test_vl_zero();
    test_back_to_back();
`ifdef TT_MASK_IDX_RX_ERR_EN
    test_proto_err();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
